// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and memory port of the shared-bus arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              i_data_ok;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W/8-1:0] d_strobe;
  logic              d_data_ok;
  logic [DATA_W-1:0] d_rdata;
  logic              m_valid;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W/8-1:0] m_strobe;
  logic              m_ready;
  logic [DATA_W-1:0] m_rdata;
  modport slave (
    input  i_req, i_addr, i_flush, d_req, d_write, d_addr, d_wdata, d_strobe, m_ready, m_rdata,
    output i_data_ok, i_rdata, d_data_ok, d_rdata, m_valid, m_write, m_addr, m_wdata, m_strobe
  );
  modport master (
    output i_req, i_addr, i_flush, d_req, d_write, d_addr, d_wdata, d_strobe, m_ready, m_rdata,
    input  i_data_ok, i_rdata, d_data_ok, d_rdata, m_valid, m_write, m_addr, m_wdata, m_strobe
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory bus between fetch and data stages
module mem_arbiter (
  input logic         clk,
  input logic         resetn,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state, state_nx;
  logic last_d, drop;
  logic i_live, d_live, grant_i, grant_d, done, i_done, d_done;
  // a port still showing its completion pulse may not yet have dropped its request
  always_comb begin
    i_live   = bus.i_req & ~bus.i_data_ok;
    d_live   = bus.d_req & ~bus.d_data_ok;
    grant_d  = state == IDLE && d_live && (!i_live || !last_d);
    grant_i  = state == IDLE && i_live && !grant_d;
    done     = bus.m_valid & bus.m_ready;
    i_done   = state == BUSY_I && done && !drop && !bus.i_flush;
    d_done   = state == BUSY_D && done;
    state_nx = grant_d ? BUSY_D : grant_i ? BUSY_I : done ? IDLE : state;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_d        <= 1'b0;
      drop          <= 1'b0;
      bus.i_data_ok <= 1'b0;
      bus.d_data_ok <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.m_valid   <= 1'b0;
      bus.m_write   <= 1'b0;
      bus.m_addr    <= '0;
      bus.m_wdata   <= '0;
      bus.m_strobe  <= '0;
    end else begin
      bus.i_data_ok <= i_done;
      bus.d_data_ok <= d_done;
      drop          <= state == BUSY_I && !done && (drop || bus.i_flush);
      if (grant_d || grant_i) begin
        bus.m_valid  <= 1'b1;
        last_d       <= grant_d;
        bus.m_write  <= grant_d & bus.d_write;
        bus.m_addr   <= grant_d ? bus.d_addr : bus.i_addr;
        bus.m_wdata  <= grant_d ? bus.d_wdata : '0;
        bus.m_strobe <= (grant_d && bus.d_write) ? bus.d_strobe : '0;
      end else if (done) bus.m_valid <= 1'b0;
      if (i_done) bus.i_rdata <= bus.m_rdata;
      if (d_done) bus.d_rdata <= bus.m_write ? '0 : bus.m_rdata;
    end
  end
endmodule
